draw_bg_fx: RTL and testbench

DRAW_BG_FX -- requirements
Module: draw_bg_fx

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_if.sv | 15 +
 rtl/vblnk_edge.sv | 21 ++
 rtl/draw_bg_fx.sv | 193 +++++++++++++++++++
 tb/tb_draw_bg_fx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, background colours and flash FSM state type.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    localparam logic [11:0] BORDER_RGB_DEF = 12'hfa5;
    localparam logic [11:0] FELT_RGB_DEF   = 12'h0a0;
    localparam logic [11:0] OUTER_RGB_DEF  = 12'h080;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ON,
        OFF
    } bg_fx_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between drawing stages.
interface vga_if;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vblnk_edge.sv
// One-cycle frame tick on the rising edge of vertical blanking.
module vblnk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vblnk,
    output logic o_tick
);

    logic r_vblnk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_d <= 1'b0;
        end else begin
            r_vblnk_d <= i_vblnk;
        end
    end

    assign o_tick = i_vblnk & ~r_vblnk_d;

endmodule

// File: rtl/draw_bg_fx.sv
// Background painter (outer / border / felt) with optional frame-synchronous felt flash.
// Flash FSM, counters and colour latch exist only when DRAW_BG_FX_FLASH_EN is defined.
module draw_bg_fx
    import vga_pkg::*;
#(
    parameter int unsigned BORDER_W     = 20,
    parameter int unsigned TABLE_X0     = 100,
    parameter int unsigned TABLE_X1     = 924,
    parameter int unsigned TABLE_Y0     = 100,
    parameter int unsigned TABLE_Y1     = 668,
    parameter logic [11:0] BORDER_RGB   = BORDER_RGB_DEF,
    parameter logic [11:0] FELT_RGB     = FELT_RGB_DEF,
    parameter logic [11:0] OUTER_RGB    = OUTER_RGB_DEF,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned FLASH_COUNT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    vga_if.in           vga_bg_in,
    vga_if.out          vga_bg_out,
    input  logic        flash_start,
    input  logic [11:0] flash_rgb,
    output logic        busy
);

    localparam logic [10:0] L_X0   = 11'(TABLE_X0);
    localparam logic [10:0] L_X1   = 11'(TABLE_X1);
    localparam logic [10:0] L_Y0   = 11'(TABLE_Y0);
    localparam logic [10:0] L_Y1   = 11'(TABLE_Y1);
    localparam logic [10:0] L_BW   = 11'(BORDER_W);
    localparam logic [10:0] L_HMAX = 11'(HOR_PIXELS - int'(BORDER_W));
    localparam logic [10:0] L_VMAX = 11'(VER_PIXELS - int'(BORDER_W));

    logic [11:0] w_felt_rgb;
    logic [11:0] w_rgb;
    logic        w_felt;
    logic        w_border;
    logic        w_unused_rgb_in;

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic [11:0] r_rgb;

    // Incoming rgb is replaced entirely by the generated background.
    assign w_unused_rgb_in = ^vga_bg_in.rgb;

    always_comb begin
        w_felt   = (vga_bg_in.hcount > L_X0) && (vga_bg_in.hcount < L_X1) &&
                   (vga_bg_in.vcount > L_Y0) && (vga_bg_in.vcount < L_Y1);
        w_border = (vga_bg_in.vcount < L_BW) || (vga_bg_in.vcount > L_VMAX) ||
                   (vga_bg_in.hcount < L_BW) || (vga_bg_in.hcount > L_HMAX);
        if (vga_bg_in.hblnk || vga_bg_in.vblnk) begin
            w_rgb = 12'h000;
        end else if (w_felt) begin
            w_rgb = w_felt_rgb;
        end else if (w_border) begin
            w_rgb = BORDER_RGB;
        end else begin
            w_rgb = OUTER_RGB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_hcount <= vga_bg_in.hcount;
            r_vcount <= vga_bg_in.vcount;
            r_hsync  <= vga_bg_in.hsync;
            r_vsync  <= vga_bg_in.vsync;
            r_hblnk  <= vga_bg_in.hblnk;
            r_vblnk  <= vga_bg_in.vblnk;
            r_rgb    <= w_rgb;
        end
    end

    assign vga_bg_out.hcount = r_hcount;
    assign vga_bg_out.vcount = r_vcount;
    assign vga_bg_out.hsync  = r_hsync;
    assign vga_bg_out.vsync  = r_vsync;
    assign vga_bg_out.hblnk  = r_hblnk;
    assign vga_bg_out.vblnk  = r_vblnk;
    assign vga_bg_out.rgb    = r_rgb;

`ifdef DRAW_BG_FX_FLASH_EN
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int PW = $clog2(FLASH_COUNT + 1);
    localparam logic [FW-1:0] L_FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [PW-1:0] L_PHASES     = PW'(FLASH_COUNT);

    bg_fx_state_t  r_state;
    bg_fx_state_t  w_state_nxt;
    logic [FW-1:0] r_frame_cnt;
    logic [FW-1:0] w_frame_cnt_nxt;
    logic [PW-1:0] r_phase_cnt;
    logic [PW-1:0] w_phase_cnt_nxt;
    logic [11:0]   r_flash_rgb;
    logic [11:0]   w_flash_rgb_nxt;
    logic          r_busy;
    logic          w_frame_tick;

    vblnk_edge u_vblnk_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vblnk (vga_bg_in.vblnk),
        .o_tick  (w_frame_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            r_phase_cnt <= '0;
            r_flash_rgb <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_phase_cnt <= w_phase_cnt_nxt;
            r_flash_rgb <= w_flash_rgb_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // A start accepted in IDLE takes priority over a coincident tick; ARMED waits for the next one.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_phase_cnt_nxt = r_phase_cnt;
        w_flash_rgb_nxt = r_flash_rgb;
        case (r_state)
            IDLE: begin
                if (flash_start) begin
                    w_state_nxt     = ARMED;
                    w_flash_rgb_nxt = flash_rgb;
                    w_phase_cnt_nxt = L_PHASES;
                    w_frame_cnt_nxt = '0;
                end
            end
            ARMED: begin
                if (w_frame_tick) begin
                    w_state_nxt     = ON;
                    w_frame_cnt_nxt = '0;
                end
            end
            ON: begin
                if (w_frame_tick) begin
                    if (r_frame_cnt == L_FRAME_LAST) begin
                        w_state_nxt     = OFF;
                        w_frame_cnt_nxt = '0;
                        if (r_phase_cnt != '0) begin
                            w_phase_cnt_nxt = r_phase_cnt - PW'(1);
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FW'(1);
                    end
                end
            end
            OFF: begin
                if (w_frame_tick) begin
                    if (r_frame_cnt == L_FRAME_LAST) begin
                        w_frame_cnt_nxt = '0;
                        w_state_nxt     = (r_phase_cnt == '0) ? IDLE : ON;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_felt_rgb = (r_state == ON) ? r_flash_rgb : FELT_RGB;
    assign busy       = r_busy;
`else
    logic w_unused_flash;

    assign w_unused_flash = ^{flash_start, flash_rgb};
    assign w_felt_rgb     = FELT_RGB;
    assign busy           = 1'b0;
`endif

endmodule

// File: tb/tb_draw_bg_fx.sv
// Randomised scoreboard bench for draw_bg_fx against a frame-level flash model.
`timescale 1ns/1ps
module tb_draw_bg_fx;
  import vga_pkg::*;

  localparam int FF = 2;
  localparam int FC = 2;
  localparam int W  = 39;
`ifdef DRAW_BG_FX_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flash_start;
  logic [11:0] flash_rgb;
  logic        busy;

  vga_if in_if ();
  vga_if out_if ();

  draw_bg_fx #(.FLASH_FRAMES(FF), .FLASH_COUNT(FC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_bg_in  (in_if),
    .vga_bg_out (out_if),
    .flash_start(flash_start),
    .flash_rgb  (flash_rgb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Handshake: the DUT has no valid/ready; every driven pixel produces exactly one
  // output one clock later, so each push is matched by the pop after the next rising edge.
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level flash model: position counted in frame ticks since the first tick after start.
  bit          m_active;
  bit          m_started;
  int          m_pos;
  logic [11:0] m_rgb;
  logic        m_prev_vblnk;

  function automatic logic [11:0] ref_rgb(input logic [10:0] h, input logic [10:0] v,
                                          input logic hb, input logic vb, input logic [11:0] felt);
    if (hb || vb) return 12'h000;
    if (h > 100 && h < 924 && v > 100 && v < 668) return felt;
    if (v < 20 || v > VER_PIXELS - 20 || h < 20 || h > HOR_PIXELS - 20) return 12'hfa5;
    return 12'h080;
  endfunction

  task automatic model_reset();
    m_active = 0; m_started = 0; m_pos = 0; m_rgb = '0; m_prev_vblnk = 1'b0;
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] rgb_in,
                       input logic start, input logic [11:0] frgb);
    logic        tick;
    logic [11:0] felt;
    logic [11:0] exp_rgb;
    @(negedge clk);
    in_if.hcount = h; in_if.vcount = v; in_if.hsync = hs; in_if.vsync = vs;
    in_if.hblnk = hb; in_if.vblnk = vb; in_if.rgb = rgb_in;
    flash_start = start; flash_rgb = frgb;
    felt = 12'h0a0;
    if (m_active && m_started && ((m_pos / FF) % 2 == 0)) felt = m_rgb;
    exp_rgb = ref_rgb(h, v, hb, vb, felt);
    tick = vb && !m_prev_vblnk;
    m_prev_vblnk = vb;
    if (!m_active) begin
      if (start && FLASH_EN) begin
        m_active = 1; m_started = 0; m_rgb = frgb;
      end
    end else if (!m_started) begin
      if (tick) begin m_started = 1; m_pos = 0; end
    end else if (tick) begin
      m_pos++;
      if (m_pos == 2 * FF * FC) m_active = 0;
    end
    exp_q.push_back({h, v, hs, vs, hb, vb, exp_rgb, logic'(m_active)});
  endtask

  task automatic rand_pix(input logic vb, input logic start, input logic [11:0] frgb);
    logic [10:0] h, v;
    case ($urandom_range(0, 3))
      0: begin h = 11'($urandom_range(101, 923)); v = 11'($urandom_range(101, 667)); end
      1: begin h = 11'($urandom_range(0, 19));    v = 11'($urandom_range(0, 767));  end
      default: begin h = 11'($urandom_range(0, 1023)); v = 11'($urandom_range(0, 767)); end
    endcase
    drive(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0), vb, 12'($urandom), start, frgb);
  endtask

  task automatic run_frame(input int n_pix, input int start_at, input logic [11:0] frgb);
    for (int i = 0; i < n_pix + 3; i++) rand_pix(i >= n_pix, i == start_at, frgb);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] out_vec();
    return {out_if.hcount, out_if.vcount, out_if.hsync, out_if.vsync,
            out_if.hblnk, out_if.vblnk, out_if.rgb, busy};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    flash_start = 1'b0;
    in_if.vblnk = 1'b0;
    #1;
    check("reset_async_out", out_vec(), '0);
    model_reset();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per output cycle, away from the active edge.
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = out_vec();
        n_checks++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL pixel_out @%0t: got %h (rgb %h busy %b) required %h (rgb %h busy %b)",
                   $time, act_v, act_v[12:1], act_v[0], exp_v, exp_v[12:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dh[10] = '{50, 10, 512, 512, 100, 101, 512, 512, 300, 300};
    int dv[10] = '{50, 300, 384, 384, 384, 384, 748, 749, 20, 19};
    bit in_off;
    rst_n = 1'b0;
    flash_start = 1'b0; flash_rgb = '0;
    in_if.hcount = '0; in_if.vcount = '0; in_if.hsync = 1'b0; in_if.vsync = 1'b0;
    in_if.hblnk = 1'b0; in_if.vblnk = 1'b0; in_if.rgb = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 check("reset_init_out", out_vec(), '0);
    #1 rst_n = 1'b1;

    // Directed static map and boundary pixels; index 3 is horizontally blanked.
    for (int i = 0; i < 10; i++)
      drive(11'(dh[i]), 11'(dv[i]), 1'(i % 2), 1'(i / 5), (i == 3), 1'b0, 12'habc, 1'b0, 12'h000);
    for (int i = 0; i < 40; i++) rand_pix(1'b0, 1'b0, 12'h000);

    run_frame(20, -1, 12'h000);
    run_frame(20, -1, 12'h000);
    // Flash red, then a second request during ON that must be ignored.
    run_frame(20, 5, 12'hf00);
    run_frame(20, 3, 12'h00f);
    for (int k = 0; k < 20 && m_active; k++) run_frame(20, -1, 12'h000);
    run_frame(20, -1, 12'h000);

    // Start coincident with the vblnk rising edge: tick must not be consumed.
    run_frame(20, 20, 12'h0ff);
    for (int k = 0; k < 20 && m_active; k++) run_frame(20, -1, 12'h000);

    // Reset while in OFF, then the following frame must show the plain felt.
    run_frame(20, 2, 12'hf0f);
    in_off = 0;
    for (int k = 0; k < 20 && !in_off; k++) begin
      if (m_active && m_started && ((m_pos / FF) % 2 == 1)) in_off = 1;
      else run_frame(20, -1, 12'h000);
    end
`ifdef DRAW_BG_FX_FLASH_EN
    n_checks++;
    if (!in_off) begin
      n_fail++;
      $display("FAIL reach_off: got in_off=%0d required 1", in_off);
    end
`endif
    do_reset();
    run_frame(20, -1, 12'h000);
    run_frame(20, -1, 12'h000);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
